// File: rtl/sm_step_planner.sv
// Planning stage for the stepper pulse generator: turns an ADC sample vs. setpoint into a
// direction + step count and hands it off with a req/ack handshake. Define STEP_CLAMP_EN to clamp N to MAX_STEPS.
module sm_step_planner #(
  parameter int SIZE        = 16,
  parameter int ADC_W       = 12,
  parameter int DEADBAND    = 4,
  parameter int SHIFT       = 2,
  parameter int MAX_STEPS   = 1000,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_valid_trig,
  input  logic [ADC_W-1:0] adc_data,
  input  logic [ADC_W-1:0] setpoint,
  input  logic             plan_enable,
  input  logic             drv_busy,
  output logic             drv_enable_SM,
  output logic             drv_dir,
  output logic [SIZE:0]    N,
  output logic             planner_busy,
  output logic             in_band,
  output logic             fault,
  output logic [7:0]       overrun_cnt
);

  localparam int              TO_W   = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(ACK_TIMEOUT);
  localparam logic [SIZE:0]   MAX_N  = (SIZE+1)'(MAX_STEPS);
  localparam logic [ADC_W:0]  DB     = (ADC_W+1)'(DEADBAND);
`ifdef STEP_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_CALC, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [ADC_W-1:0] adc_q, adc_d, sp_q, sp_d;
  logic [SIZE:0]    n_q, n_d;
  logic             dir_q, dir_d, req_q, req_d, inb_q, inb_d, fault_q, fault_d;
  logic [7:0]       ovr_q, ovr_d;
  logic [TO_W-1:0]  to_q, to_d;

  logic [ADC_W:0]   err, mag, mag_sh;
  logic [SIZE:0]    steps, steps_cl;

  // Move arithmetic works on the captured sample pair, so it is stable during CALC.
  always_comb begin
    err      = {1'b0, adc_q} - {1'b0, sp_q};
    mag      = err[ADC_W] ? ({1'b0, sp_q} - {1'b0, adc_q}) : err;
    mag_sh   = mag >> SHIFT;
    steps    = (SIZE+1)'(mag_sh);
    steps_cl = (CLAMP && (steps > MAX_N)) ? MAX_N : steps;
  end

  always_comb begin
    state_d = state_q;
    adc_d   = adc_q;
    sp_d    = sp_q;
    n_d     = n_q;
    dir_d   = dir_q;
    req_d   = req_q;
    inb_d   = inb_q;
    fault_d = fault_q;
    to_d    = to_q;
    ovr_d   = ovr_q;

    if (data_valid_trig && (state_q != S_IDLE) && (ovr_q != 8'hFF))
      ovr_d = ovr_q + 8'd1;

    case (state_q)
      S_IDLE: begin
        if (data_valid_trig && plan_enable && !fault_q) begin
          adc_d   = adc_data;
          sp_d    = setpoint;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        // A nonzero error that shifts down to zero steps is as good as in-band.
        if ((mag <= DB) || (steps == '0)) begin
          inb_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          n_d     = steps_cl;
          dir_d   = ~err[ADC_W];
          inb_d   = 1'b0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        req_d   = 1'b1;
        to_d    = '0;
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (drv_busy) begin
          req_d   = 1'b0;
          state_d = S_WAIT_DONE;
        end else if (!plan_enable) begin
          req_d   = 1'b0;
          state_d = S_IDLE;
        end else if (to_q == TO_MAX) begin
          req_d   = 1'b0;
          fault_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!drv_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (!plan_enable) fault_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      adc_q   <= '0;
      sp_q    <= '0;
      n_q     <= '0;
      dir_q   <= 1'b0;
      req_q   <= 1'b0;
      inb_q   <= 1'b0;
      fault_q <= 1'b0;
      to_q    <= '0;
      ovr_q   <= '0;
    end else begin
      state_q <= state_d;
      adc_q   <= adc_d;
      sp_q    <= sp_d;
      n_q     <= n_d;
      dir_q   <= dir_d;
      req_q   <= req_d;
      inb_q   <= inb_d;
      fault_q <= fault_d;
      to_q    <= to_d;
      ovr_q   <= ovr_d;
    end
  end

  assign drv_enable_SM = req_q;
  assign drv_dir       = dir_q;
  assign N             = n_q;
  assign planner_busy  = (state_q != S_IDLE);
  assign in_band       = inb_q;
  assign fault         = fault_q;
  assign overrun_cnt   = ovr_q;

endmodule

// File: tb/tb_sm_step_planner.sv
// Bench for sm_step_planner: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a transaction-level model.
module tb_sm_step_planner;
  localparam int SIZE = 16, ADC_W = 12, DEADBAND = 4, SHIFT = 2, MAX_STEPS = 1000, ACK_TIMEOUT = 255;
`ifdef STEP_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b0, trig = 1'b0, en = 1'b0, busy = 1'b0;
  logic [ADC_W-1:0] adc = '0, sp = '0;
  logic req, dir, pbusy, inb, flt;
  logic [SIZE:0] n;
  logic [7:0] ovr;
  int checks = 0, errors = 0;

  sm_step_planner #(
    .SIZE(SIZE), .ADC_W(ADC_W), .DEADBAND(DEADBAND), .SHIFT(SHIFT),
    .MAX_STEPS(MAX_STEPS), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .data_valid_trig(trig), .adc_data(adc), .setpoint(sp),
    .plan_enable(en), .drv_busy(busy), .drv_enable_SM(req), .drv_dir(dir), .N(n),
    .planner_busy(pbusy), .in_band(inb), .fault(flt), .overrun_cnt(ovr)
  );

  always #10 clk = ~clk;

  // Move planning from the rules, in plain integers.
  function automatic void plan(input int a, input int s, output bit ib, output int st, output bit d);
    int e, mag;
    e   = a - s;
    mag = (e < 0) ? -e : e;
    st  = mag / (1 << SHIFT);
    ib  = (mag <= DEADBAND) || (st == 0);
    if (CLAMP && st > MAX_STEPS) st = MAX_STEPS;
    d   = (a > s);
  endfunction

  // Model: phase 0 idle, 1 planning, 2 issuing, 3 requesting, 4 moving.
  int m_ph = 0, m_to = 0, m_n = 0, m_ovr = 0, p_n = 0;
  bit m_req = 0, m_dir = 0, m_inb = 0, m_fault = 0, p_dir = 0, p_inb = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ph = 0; m_to = 0; m_n = 0; m_ovr = 0;
      m_req = 0; m_dir = 0; m_inb = 0; m_fault = 0;
    end else begin
      if (trig && m_ph != 0 && m_ovr < 255) m_ovr = m_ovr + 1;
      case (m_ph)
        0: if (trig && en && !m_fault) begin
             plan(int'(adc), int'(sp), p_inb, p_n, p_dir);
             m_ph = 1;
           end
        1: begin
             m_inb = p_inb;
             if (p_inb) m_ph = 0;
             else begin m_n = p_n; m_dir = p_dir; m_ph = 2; end
           end
        2: begin m_req = 1; m_to = 0; m_ph = 3; end
        3: if (busy) begin m_req = 0; m_ph = 4; end
           else if (!en) begin m_req = 0; m_ph = 0; end
           else if (m_to == ACK_TIMEOUT) begin m_req = 0; m_fault = 1; m_ph = 0; end
           else m_to = m_to + 1;
        4: if (!busy) m_ph = 0;
        default: m_ph = 0;
      endcase
      if (!en) m_fault = 0;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      checks++;
      if (req !== m_req || dir !== m_dir || n !== (SIZE+1)'(m_n) || pbusy !== (m_ph != 0) ||
          inb !== m_inb || flt !== m_fault || ovr !== 8'(m_ovr)) begin
        errors++;
        $display("FAIL model_cycle t=%0t: got req=%0b dir=%0b N=%0d busy=%0b inb=%0b flt=%0b ovr=%0d, want %0b %0b %0d %0b %0b %0b %0d",
                 $time, req, dir, n, pbusy, inb, flt, ovr,
                 m_req, m_dir, m_n, (m_ph != 0), m_inb, m_fault, m_ovr);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic step(input int k = 1);
    repeat (k) begin @(negedge clk); #2; end
  endtask

  task automatic pulse_trig(input int a, input int s);
    adc = ADC_W'(a); sp = ADC_W'(s); trig = 1'b1; step(); trig = 1'b0;
  endtask

  task automatic finish_move();
    busy = 1'b1; step(); busy = 1'b0; step();
  endtask

  initial begin
    int cnt;
    step(2);
    chk("rst_req", req, 0); chk("rst_N", n, 0); chk("rst_dir", dir, 0); chk("rst_busy", pbusy, 0);
    chk("rst_inb", inb, 0); chk("rst_fault", flt, 0); chk("rst_ovr", ovr, 0);
    rst = 1'b1; en = 1'b1; step();

    pulse_trig(2100, 2000);
    chk("calc_busy", pbusy, 1); chk("calc_req", req, 0);
    step(); chk("issue_req", req, 0);
    step(); chk("move_req", req, 1); chk("move_N", n, 25); chk("move_dir", dir, 1);
    busy = 1'b1; step(); chk("ack_req_lo", req, 0); chk("wait_done_busy", pbusy, 1);
    step(); chk("moving_busy", pbusy, 1);
    busy = 1'b0; step(); chk("done_idle", pbusy, 0);

    pulse_trig(1997, 2000); chk("inband_busy1", pbusy, 1);
    step(); chk("inband_flag", inb, 1); chk("inband_idle", pbusy, 0); chk("inband_req", req, 0);
    chk("inband_holdN", n, 25);
    pulse_trig(2006, 2000); step(2);
    chk("n1_req", req, 1); chk("n1_N", n, 1); chk("n1_dir", dir, 1); chk("n1_inb", inb, 0);
    finish_move();
    pulse_trig(1900, 2000); step(2); chk("neg_N", n, 25); chk("neg_dir", dir, 0);
    finish_move();
    pulse_trig(4095, 0); step(2); chk("clamp_N", n, CLAMP ? 1000 : 1023);
    finish_move();

    pulse_trig(2100, 2000); step(2); busy = 1'b1; step();
    trig = 1'b1; step(300); trig = 1'b0;
    chk("ovr_sat", ovr, 255); chk("ovr_N", n, 25); chk("ovr_busy", pbusy, 1);
    busy = 1'b0; step(); chk("ovr_idle", pbusy, 0);

    rst = 1'b0; step(); rst = 1'b1; step();
    pulse_trig(2100, 2000); step(2); busy = 1'b1; step();
    busy = 1'b0; trig = 1'b1; step(); trig = 1'b0;
    chk("edge_ovr", ovr, 1); chk("edge_not_captured", pbusy, 0);

    pulse_trig(2100, 2000); step(2);
    cnt = 0;
    for (int i = 0; i < 400 && req; i++) begin cnt++; step(); end
    chk("to_cycles", cnt, 256); chk("to_fault", flt, 1); chk("to_idle", pbusy, 0);
    pulse_trig(2100, 2000); chk("fault_ignore", pbusy, 0); step(2); chk("fault_noreq", req, 0);
    en = 1'b0; step(); chk("fault_clear", flt, 0); en = 1'b1;
    pulse_trig(2100, 2000); chk("post_clear_busy", pbusy, 1); step(2); chk("post_clear_req", req, 1);
    en = 1'b0; step(); chk("en_abort_req", req, 0); chk("en_abort_idle", pbusy, 0);
    chk("en_abort_fault", flt, 0); en = 1'b1; step();

    pulse_trig(2100, 2000); step(2); chk("pre_rst_req", req, 1);
    #3 rst = 1'b0; #1;
    chk("async_req", req, 0); chk("async_N", n, 0); chk("async_dir", dir, 0); chk("async_busy", pbusy, 0);
    step(); rst = 1'b1; step();

    sp = 12'd2000;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 63) == 0) sp = ADC_W'($urandom_range(200, 3800));
      if ($urandom_range(0, 3) == 0) adc = ADC_W'($urandom_range(0, 4095));
      else adc = ADC_W'(int'(sp) + int'($urandom_range(0, 80)) - 40);
      trig = ($urandom_range(0, 5) == 0);
      en   = ($urandom_range(0, 49) != 0);
      if ($urandom_range(0, 7) == 0) busy = ~busy;
      step();
    end
    trig = 1'b0;
    step(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
